// File: rtl/ssm_mult_pipe.sv
// Static-segment approximate multiplier with a 3-stage elastic valid/ready
// pipeline, runtime exact/approximate mode and a saturating approximation counter.
module ssm_mult_pipe #(
  parameter int N     = 23,
  parameter int M     = 16,
  parameter int CORR  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   ris,
  output logic             out_approx,
  output logic [CNT_W-1:0] approx_cnt,
  input  logic             cnt_clr
);

  localparam int SH = N - M;
  localparam int PW = 2 * N;
  localparam int MW = 2 * M + 2;
  localparam int SW = $clog2(2 * SH + 1);

  // Handshake: a transfer happens on any clock edge where valid & ready are both
  // high. A stage loads when it is empty or its content leaves downstream this
  // cycle; in_ready is combinational from out_ready through that chain.

  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_a_q, s1_a_d;
  logic [N-1:0]     s1_b_q, s1_b_d;
  logic             s1_alpha_a_q, s1_alpha_a_d;
  logic             s1_alpha_b_q, s1_alpha_b_d;
  logic             s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    s2_prod_q, s2_prod_d;
  logic             s2_approx_q, s2_approx_d;

  logic             s3_valid_q, s3_valid_d;
  logic [PW-1:0]    s3_prod_q, s3_prod_d;
  logic             s3_approx_q, s3_approx_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s3_moves, s3_load, s2_load, s1_load;

  logic [M-1:0]     seg_a, seg_b;
  logic [M:0]       op_a, op_b;
  logic [SW-1:0]    sh_a, sh_b, sh_tot;
  logic [MW-1:0]    mul_apx;
  logic [PW-1:0]    prod_apx, prod_ex;

  always_comb begin
    s3_moves = s3_valid_q & out_ready;
    s3_load  = !s3_valid_q | s3_moves;
    s2_load  = !s2_valid_q | s3_load;
    s1_load  = !s1_valid_q | s2_load;
    in_ready = s1_load;
  end

  // Stage 1: capture operands, segment selectors and mode.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_alpha_a_d = s1_alpha_a_q;
    s1_alpha_b_d = s1_alpha_b_q;
    s1_mode_d    = s1_mode_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d       = a;
        s1_b_d       = b;
        s1_alpha_a_d = |a[N-1:M];
        s1_alpha_b_d = |b[N-1:M];
        s1_mode_d    = approx_en;
      end
    end
  end

  // x_hat = (seg << sh) + c << (sh-1) == {seg, c} << (sh-1) for upper segments.
  always_comb begin
    seg_a    = s1_alpha_a_q ? s1_a_q[N-1:SH] : s1_a_q[M-1:0];
    seg_b    = s1_alpha_b_q ? s1_b_q[N-1:SH] : s1_b_q[M-1:0];
    op_a     = s1_alpha_a_q ? {seg_a, (CORR != 0)} : {1'b0, seg_a};
    op_b     = s1_alpha_b_q ? {seg_b, (CORR != 0)} : {1'b0, seg_b};
    sh_a     = s1_alpha_a_q ? SW'(SH - 1) : '0;
    sh_b     = s1_alpha_b_q ? SW'(SH - 1) : '0;
    sh_tot   = sh_a + sh_b;
    mul_apx  = MW'(op_a) * MW'(op_b);
    prod_apx = PW'(mul_apx) << sh_tot;
    prod_ex  = PW'(s1_a_q) * PW'(s1_b_q);
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_approx_d = s2_approx_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d   = s1_mode_q ? prod_apx : prod_ex;
        s2_approx_d = s1_mode_q & (s1_alpha_a_q | s1_alpha_b_q);
      end
    end
  end

  always_comb begin
    s3_valid_d  = s3_valid_q;
    s3_prod_d   = s3_prod_q;
    s3_approx_d = s3_approx_q;
    if (s3_load) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_prod_d   = s2_prod_q;
        s3_approx_d = s2_approx_q;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s3_moves && s3_approx_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_alpha_a_q <= 1'b0;
      s1_alpha_b_q <= 1'b0;
      s1_mode_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_prod_q    <= '0;
      s2_approx_q  <= 1'b0;
      s3_valid_q   <= 1'b0;
      s3_prod_q    <= '0;
      s3_approx_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_alpha_a_q <= s1_alpha_a_d;
      s1_alpha_b_q <= s1_alpha_b_d;
      s1_mode_q    <= s1_mode_d;
      s2_valid_q   <= s2_valid_d;
      s2_prod_q    <= s2_prod_d;
      s2_approx_q  <= s2_approx_d;
      s3_valid_q   <= s3_valid_d;
      s3_prod_q    <= s3_prod_d;
      s3_approx_q  <= s3_approx_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = s3_valid_q;
  assign ris        = s3_prod_q;
  assign out_approx = s3_approx_q;
  assign approx_cnt = cnt_q;

endmodule
